disp_mode_ctrl: RTL and testbench

DISP_MODE_CTRL -- requirements
Module: disp_mode_ctrl

---
 rtl/disp_mode_ctrl_pkg.sv | 29 ++
 rtl/disp_mode_ctrl_if.sv | 22 ++
 rtl/disp_mode_ctrl_btn_rise.sv | 17 +
 rtl/disp_mode_ctrl.sv | 130 +++++++++++++
 tb/tb_disp_mode_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_mode_ctrl_pkg.sv
// Shared types and constants for the alarm-clock display mode controller.
// Optional feature macro (used by the top): DISP_AUTO_REPEAT_EN.
package disp_ctrl_pkg;

    typedef enum logic [1:0] {
        TIME     = 2'd0,
        VIEW_ALM = 2'd1,
        EDIT_HH  = 2'd2,
        EDIT_MM  = 2'd3
    } disp_state_e;

    localparam logic [3:0] BLINK_NONE = 4'b0000;
    localparam logic [3:0] BLINK_HH   = 4'b1100;
    localparam logic [3:0] BLINK_MM   = 4'b0011;

    localparam int unsigned TIMEOUT_S_DEF    = 10;
    localparam int unsigned REPEAT_DLY_S_DEF = 2;

    function automatic disp_state_e next_mode(input disp_state_e s);
        case (s)
            TIME:     return VIEW_ALM;
            VIEW_ALM: return EDIT_HH;
            EDIT_HH:  return EDIT_MM;
            EDIT_MM:  return TIME;
            default:  return TIME;
        endcase
    endfunction

endpackage

// File: rtl/disp_mode_ctrl_if.sv
// Button/tick inputs and display-control outputs of disp_mode_ctrl.
// master drives buttons and tick; slave is the controller.
interface disp_mode_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       sel;
    logic [1:0] mode;
    logic [3:0] blink_mask;
    logic       inc_hh;
    logic       inc_mm;

    modport master (
        output tick_1hz, btn_mode, btn_inc,
        input  sel, mode, blink_mask, inc_hh, inc_mm
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc,
        output sel, mode, blink_mask, inc_hh, inc_mm
    );
endinterface

// File: rtl/disp_mode_ctrl_btn_rise.sv
// Rising-edge detector for one debounced button level.
// The sample register resets to 1 so a button held through reset gives no rise.
module btn_rise (
    input  logic clk,
    input  logic reset_,
    input  logic btn,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) prev <= 1'b1;
        else         prev <= btn;
    end

    assign rise = btn & ~prev;
endmodule

// File: rtl/disp_mode_ctrl.sv
// Display mode controller: TIME/VIEW_ALM/EDIT_HH/EDIT_MM with idle timeout and blink.
// Define DISP_AUTO_REPEAT_EN to enable btn_inc auto-repeat in the edit states.
module disp_mode_ctrl
    import disp_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_S    = TIMEOUT_S_DEF,
    parameter int unsigned REPEAT_DLY_S = REPEAT_DLY_S_DEF
) (
    input logic            clk,
    input logic            reset_,
    disp_mode_ctrl_if.slave bus
);
    if (TIMEOUT_S < 2 || TIMEOUT_S > 63 || REPEAT_DLY_S < 1 || REPEAT_DLY_S > 15) begin : g_bad_cfg
        $error("disp_mode_ctrl: parameter out of range");
    end

    // Terminal tick fires when the count is one below the limit.
    localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT_S - 1);

    logic        mode_rise;
    logic        inc_rise;
    disp_state_e state, state_nx;
    logic [5:0]  idle_cnt, idle_nx;
    logic        phase, phase_nx;
    logic        sel_q, sel_nx;
    logic [3:0]  mask_q, mask_nx;
    logic        hh_q, hh_nx;
    logic        mm_q, mm_nx;
    logic        in_edit;
    logic        rpt_fire;
    logic        activity;

    btn_rise u_mode_rise (
        .clk    (clk),
        .reset_ (reset_),
        .btn    (bus.btn_mode),
        .rise   (mode_rise)
    );

    btn_rise u_inc_rise (
        .clk    (clk),
        .reset_ (reset_),
        .btn    (bus.btn_inc),
        .rise   (inc_rise)
    );

    assign in_edit = (state == EDIT_HH) || (state == EDIT_MM);

`ifdef DISP_AUTO_REPEAT_EN
    localparam logic [3:0] RPT_DLY = 4'(REPEAT_DLY_S);

    logic [3:0] rpt_cnt, rpt_nx;

    // Counts ticks while held since the rise; saturates once repeating.
    always_comb begin
        rpt_nx   = rpt_cnt;
        rpt_fire = 1'b0;
        if (!in_edit || !bus.btn_inc || inc_rise) begin
            rpt_nx = '0;
        end else if (bus.tick_1hz) begin
            if (rpt_cnt >= RPT_DLY) rpt_fire = 1'b1;
            else                    rpt_nx   = rpt_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) rpt_cnt <= '0;
        else         rpt_cnt <= rpt_nx;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign activity = mode_rise | inc_rise | rpt_fire;

    always_comb begin
        state_nx = state;
        hh_nx    = 1'b0;
        mm_nx    = 1'b0;
        if (mode_rise) begin
            state_nx = next_mode(state);
        end else begin
            if (inc_rise || rpt_fire) begin
                hh_nx = (state == EDIT_HH);
                mm_nx = (state == EDIT_MM);
            end
            if (!activity && bus.tick_1hz && state != TIME && idle_cnt == IDLE_LAST)
                state_nx = TIME;
        end

        if (activity || state_nx == TIME) idle_nx = '0;
        else if (bus.tick_1hz)           idle_nx = idle_cnt + 6'd1;
        else                             idle_nx = idle_cnt;

        if (state_nx != EDIT_HH && state_nx != EDIT_MM) phase_nx = 1'b0;
        else if (bus.tick_1hz && in_edit)               phase_nx = ~phase;
        else                                            phase_nx = phase;

        sel_nx = (state_nx != TIME);
        if (phase_nx && state_nx == EDIT_HH)      mask_nx = BLINK_HH;
        else if (phase_nx && state_nx == EDIT_MM) mask_nx = BLINK_MM;
        else                                      mask_nx = BLINK_NONE;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= TIME;
            idle_cnt <= '0;
            phase    <= 1'b0;
            sel_q    <= 1'b0;
            mask_q   <= '0;
            hh_q     <= 1'b0;
            mm_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_nx;
            phase    <= phase_nx;
            sel_q    <= sel_nx;
            mask_q   <= mask_nx;
            hh_q     <= hh_nx;
            mm_q     <= mm_nx;
        end
    end

    assign bus.mode       = state;
    assign bus.sel        = sel_q;
    assign bus.blink_mask = mask_q;
    assign bus.inc_hh     = hh_q;
    assign bus.inc_mm     = mm_q;
endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Self-checking bench for disp_mode_ctrl against a cycle-level behavioural model.
module tb_disp_mode_ctrl;
    localparam int TIMEOUT    = 10;
    localparam int REPEAT_DLY = 2;

    logic clk = 1'b0;
    logic reset_;
    int   n_cmp  = 0;
    int   n_fail = 0;

    disp_mode_ctrl_if bif ();

    disp_mode_ctrl #(.TIMEOUT_S(TIMEOUT), .REPEAT_DLY_S(REPEAT_DLY)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bif.slave)
    );

    always #5 clk = ~clk;

    // Model: integer mode 0..3, idle seconds, blink phase, ticks seen while held.
    int m_mode, m_idle, m_hold;
    bit m_phase, m_pbm, m_pbi;
    logic [8:0] exp_v;
    logic e_hh, e_mm;

    function automatic logic [8:0] obs();
        return {bif.sel, bif.mode, bif.blink_mask, bif.inc_hh, bif.inc_mm};
    endfunction

    function automatic logic [8:0] pack_exp(int md, bit ph, bit hh, bit mm);
        logic [3:0] mk;
        if (md == 2 && ph)      mk = 4'b1100;
        else if (md == 3 && ph) mk = 4'b0011;
        else                    mk = 4'b0000;
        return {md != 0, 2'(md), mk, hh, mm};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idle = 0; m_hold = 0; m_phase = 0;
        m_pbm = 1; m_pbi = 1; e_hh = 0; e_mm = 0;
        exp_v = '0;
    endtask

    task automatic cycle(input bit t, input bit bm, input bit bi);
        bit rm, ri, rep, was_edit;
        bif.tick_1hz = t; bif.btn_mode = bm; bif.btn_inc = bi;
        @(posedge clk);
        rm = bm && !m_pbm;
        ri = bi && !m_pbi;
        m_pbm = bm; m_pbi = bi;
        was_edit = (m_mode >= 2);
        rep = 0;
`ifdef DISP_AUTO_REPEAT_EN
        if (!was_edit || !bi || ri) m_hold = 0;
        else if (t) begin
            if (m_hold >= REPEAT_DLY) rep = 1;
            m_hold++;
        end
`endif
        e_hh = 0; e_mm = 0;
        if (rm) begin
            m_mode = (m_mode + 1) % 4;
            m_idle = 0;
        end else if (ri || rep) begin
            e_hh = (m_mode == 2);
            e_mm = (m_mode == 3);
            m_idle = 0;
        end else if (t && m_mode != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) m_mode = 0;
        end
        if (m_mode == 0) m_idle = 0;
        if (m_mode < 2)            m_phase = 0;
        else if (t && was_edit)    m_phase = !m_phase;
        exp_v = pack_exp(m_mode, m_phase, e_hh, e_mm);
        #1;
    endtask

    task automatic goto_mode(input int target);
        int guard = 0;
        while (m_mode != target && guard < 8) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
            guard++;
        end
    endtask

    task automatic test_reset();
        reset_ = 0;
        bif.tick_1hz = 0; bif.btn_mode = 1; bif.btn_inc = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== 9'h000) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), 9'h000);
        end
        @(negedge clk);
        reset_ = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1);
            n_cmp++;
            if (bif.mode !== 2'd0 || bif.sel !== 1'b0 || obs() !== exp_v) begin
                n_fail++; $display("FAIL held_through_reset: got %h expected %h", obs(), exp_v);
            end
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_mode_cycle();
        logic [1:0] want_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       want_sel  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0);
            n_cmp++;
            if (bif.mode !== want_mode[i] || bif.sel !== want_sel[i]) begin
                n_fail++;
                $display("FAIL mode_step%0d: got mode=%0d sel=%0b expected mode=%0d sel=%0b",
                         i, bif.mode, bif.sel, want_mode[i], want_sel[i]);
            end
            cycle(0, 0, 0);
        end
    endtask

    task automatic test_inc();
        goto_mode(3);
        cycle(0, 0, 1);
        n_cmp++;
        if (bif.inc_mm !== 1'b1 || bif.inc_hh !== 1'b0) begin
            n_fail++; $display("FAIL inc_mm_pulse: got hh=%0b mm=%0b expected hh=0 mm=1", bif.inc_hh, bif.inc_mm);
        end
        cycle(0, 0, 1);
        n_cmp++;
        if (bif.inc_mm !== 1'b0 || bif.inc_hh !== 1'b0) begin
            n_fail++; $display("FAIL inc_mm_single: got hh=%0b mm=%0b expected 0 0", bif.inc_hh, bif.inc_mm);
        end
        cycle(0, 0, 0);
        cycle(0, 1, 1);
        n_cmp++;
        if (bif.mode !== 2'd0 || bif.inc_mm !== 1'b0 || bif.inc_hh !== 1'b0) begin
            n_fail++; $display("FAIL mode_inc_same_cycle: got mode=%0d hh=%0b mm=%0b expected 0 0 0",
                               bif.mode, bif.inc_hh, bif.inc_mm);
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_timeout();
        goto_mode(1);
        for (int i = 1; i <= TIMEOUT; i++) begin
            cycle(1, 0, 0);
            n_cmp++;
            if (bif.mode !== ((i == TIMEOUT) ? 2'd0 : 2'd1)) begin
                n_fail++; $display("FAIL timeout_tick%0d: got mode=%0d expected %0d",
                                   i, bif.mode, (i == TIMEOUT) ? 0 : 1);
            end
            cycle(0, 0, 0);
        end
        goto_mode(1);
        for (int i = 1; i < TIMEOUT; i++) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
        cycle(1, 1, 0);
        n_cmp++;
        if (bif.mode !== 2'd2 || bif.sel !== 1'b1) begin
            n_fail++; $display("FAIL timeout_cancel: got mode=%0d expected 2", bif.mode);
        end
        cycle(0, 0, 0);
        goto_mode(0);
    endtask

    task automatic test_blink();
        logic [3:0] want [4] = '{4'b1100, 4'b0000, 4'b1100, 4'b0000};
        goto_mode(2);
        n_cmp++;
        if (bif.blink_mask !== 4'b0000) begin
            n_fail++; $display("FAIL blink_entry: got %b expected 0000", bif.blink_mask);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            n_cmp++;
            if (bif.blink_mask !== want[i]) begin
                n_fail++; $display("FAIL blink_hh%0d: got %b expected %b", i, bif.blink_mask, want[i]);
            end
            cycle(0, 0, 0);
        end
        cycle(0, 1, 0);
        n_cmp++;
        if (bif.mode !== 2'd3 || bif.blink_mask !== 4'b0000) begin
            n_fail++; $display("FAIL blink_mm_entry: got mode=%0d mask=%b expected 3 0000", bif.mode, bif.blink_mask);
        end
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        n_cmp++;
        if (bif.blink_mask !== 4'b0011) begin
            n_fail++; $display("FAIL blink_mm_tick: got %b expected 0011", bif.blink_mask);
        end
        goto_mode(0);
        n_cmp++;
        if (bif.blink_mask !== 4'b0000) begin
            n_fail++; $display("FAIL blink_exit: got %b expected 0000", bif.blink_mask);
        end
    endtask

    task automatic test_repeat();
        int pulses = 0;
        int want;
`ifdef DISP_AUTO_REPEAT_EN
        want = 4;
`else
        want = 1;
`endif
        goto_mode(2);
        cycle(0, 0, 1);
        pulses += int'(bif.inc_hh);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 1);
            pulses += int'(bif.inc_hh);
            repeat (2) begin
                cycle(0, 0, 1);
                pulses += int'(bif.inc_hh);
            end
        end
        n_cmp++;
        if (pulses !== want) begin
            n_fail++; $display("FAIL repeat_count: got %0d expected %0d", pulses, want);
        end
        cycle(0, 0, 0);
        goto_mode(0);
    endtask

    task automatic test_reset_mid_edit();
        goto_mode(3);
        cycle(0, 0, 1);
        reset_ = 0;
        model_reset();
        #2;
        n_cmp++;
        if (obs() !== 9'h000) begin
            n_fail++; $display("FAIL reset_mid_edit: got %h expected %h", obs(), 9'h000);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bif.inc_mm !== 1'b0 || bif.mode !== 2'd0) begin
            n_fail++; $display("FAIL reset_no_pending: got mode=%0d mm=%0b expected 0 0", bif.mode, bif.inc_mm);
        end
        @(negedge clk);
        reset_ = 1;
        cycle(0, 0, 0);
    endtask

    task automatic test_random();
        bit t, bm, bi;
        for (int i = 0; i < 3000; i++) begin
            t  = ($urandom_range(0, 3) == 0);
            bm = (i % 97 < 60) ? 1'b0 : ($urandom_range(0, 5) == 0);
            bi = ($urandom_range(0, 2) == 0) ? ~m_pbi : m_pbi;
            if (i % 200 < 100) bi = (($urandom_range(0, 15) == 0) ? ~m_pbi : m_pbi);
            cycle(t, bm, bi);
            n_cmp++;
            if (obs() !== exp_v || (bif.inc_hh && bif.inc_mm)) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), exp_v);
            end
        end
        cycle(0, 0, 0);
    endtask

    initial begin
        reset_ = 0;
        bif.tick_1hz = 0; bif.btn_mode = 0; bif.btn_inc = 0;
        test_reset();
        test_mode_cycle();
        test_inc();
        test_timeout();
        test_blink();
        test_repeat();
        test_reset_mid_edit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
